mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the LC-3 datapath's MAR/MDR memory interface. Accepts
//  read/write requests (address from MAR, write data from MDR), inserts programmable
//  wait states, returns read data with a one-cycle Ready pulse, and decodes
//  memory-mapped I/O: switches are read at 0xFFFF; writes to 0xFFFF load the hex
//  display register. Sits between the CPU datapath/control and the on-chip RAM.
// PARAMETERS
//  DEPTH        1024  words of on-chip RAM; valid RAM addresses 0..DEPTH-1
//  WAIT_STATES  2     cycles spent in WAIT per access; legal range 1..15
// PORTS
//  Clk           in   1   system clock
//  Reset         in   1   asynchronous, active-low reset
//  Req           in   1   access request (CPU MIO_EN); sampled only in IDLE
//  Wr            in   1   1 = write, 0 = read; sampled with Req
//  Addr          in   16  access address (MAR)
//  Data_from_CPU in   16  write data (MDR)
//  Switches      in   16  board switches, asynchronous to Clk
//  Data_to_CPU   out  16  read data; valid while Ready=1
//  Ready         out  1   one-cycle completion pulse (CPU R signal)
//  Hex_out       out  16  hex display register (nibbles drive HEX3..HEX0)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: state=IDLE, Ready=0, Data_to_CPU=0x0000, Hex_out=0x0000, wait
//    counter=0, switch synchronizer=0. RAM contents are not cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if Req=1, latch Addr, Wr, and Data_from_CPU; load counter=WAIT_STATES-1;
//          go to WAIT.
//    WAIT: decrement the counter; at 0, go to RESP.
//    RESP: Ready=1 for exactly one cycle; return to IDLE.
//  - Latency: Ready is high in cycle WAIT_STATES+1 after the sampling edge.
//    Example: WAIT_STATES=2 gives Ready in the third cycle after the edge.
//  - A request is committed once latched. Deasserting Req, or changing Addr or Wr,
//    in WAIT/RESP has no effect.
//  - If Req is still high in the IDLE cycle after RESP, it starts a new access.
//    Back-to-back accesses have a period of WAIT_STATES+2 cycles.
//  - Read decode (on latched address):
//    0xFFFF              -> synchronized Switches
//    < DEPTH             -> RAM[addr]
//    otherwise           -> 0x0000
//  - Write decode:
//    0xFFFF              -> Hex_out <= data
//    < DEPTH             -> RAM[addr] <= data
//    otherwise           -> discarded
//    Ready is still pulsed for every access, including discarded writes.
//  - RAM writes and Hex_out updates occur on the edge entering RESP.
//  - Data_to_CPU is registered on the edge entering RESP and holds until the next
//    read's RESP. Writes leave Data_to_CPU unchanged.
//  - Switches pass through a 2-flop synchronizer. A read returns the synchronized
//    value at the WAIT->RESP edge.
//  - Reset asserted mid-access aborts the access: no RAM or Hex write, no Ready pulse.
// STRUCTURE
//  - lc3_mem_pkg: state enum {IDLE, WAIT, RESP}; localparam MMIO_SW_HEX = 16'hFFFF.
//  - One sub-module, mem_array: synchronous single-port RAM, DEPTH x 16, with
//    1-cycle read latency. This latency is why WAIT_STATES >= 1.
//  - Top level: FSM, wait counter, address decode, Hex_out register, synchronizer.
// TESTING (WAIT_STATES=2, DEPTH=1024)
//  1. Write 0x1234 to 0x0010 -> Ready exactly 3 cycles after Req is sampled.
//     Then read 0x0010 -> Data_to_CPU=0x1234 with Ready.
//  2. Switches=0xBEEF (stable >=3 cycles), read 0xFFFF -> Data_to_CPU=0xBEEF.
//  3. Write 0x00A5 to 0xFFFF -> Hex_out=0x00A5 after the RESP edge; read 0x03FF
//     (RAM top) is unaffected.
//  4. Write 0x5555 to 0x8000 -> Ready pulses once, RAM unchanged.
//     Read 0x8000 -> 0x0000.
//  5. Hold Req=1 for 12 cycles of reads -> Ready pulses every 4 cycles, width 1.
//  6. Assert Reset in WAIT of a write to 0xFFFF -> no Ready, Hex_out=0x0000.
//     After release, FSM is IDLE and the next access works.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// State encoding, MMIO address and wait-counter width.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [15:0] MMIO_SW_HEX = 16'hFFFF;
    localparam int          CNT_W       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus (MAR/MDR side).
// The CPU is the master; the responder is the slave.
interface mem_responder_if;

    logic        Req;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Ready;

    modport master (
        output Req,
        output Wr,
        output Addr,
        output Data_from_CPU,
        input  Data_to_CPU,
        input  Ready
    );

    modport slave (
        input  Req,
        input  Wr,
        input  Addr,
        input  Data_from_CPU,
        output Data_to_CPU,
        output Ready
    );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port RAM, DEPTH x 16, one-cycle read latency.
// Contents are not reset.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory-side responder: wait states, RAM access and
// switch/hex MMIO at 0xFFFF, one-cycle Ready pulse per access.
module mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_responder_if.slave    bus,
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_out
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      dout_q, dout_d;
    logic [15:0]      hex_q, hex_d;
    logic [15:0]      sw_meta_q, sw_sync_q;

    logic             enter_resp;
    logic             hit_mmio;
    logic             hit_ram;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [15:0]      ram_rdata;

    assign enter_resp = (state_q == WAIT) && (cnt_q == '0);
    assign hit_mmio   = (addr_q == MMIO_SW_HEX);
    assign hit_ram    = (32'(addr_q) < DEPTH);
    assign ram_we     = enter_resp && wr_q && hit_ram;

    // Read from the live bus address in IDLE so data is ready
    // even when only one wait state is configured.
    assign ram_addr = (state_q == IDLE) ? bus.Addr[AW-1:0]
                                        : addr_q[AW-1:0];

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            dout_q    <= '0;
            hex_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            hex_q     <= hex_d;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Req) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        hex_d   = hex_q;
        if (state_q == IDLE && bus.Req) begin
            addr_d  = bus.Addr;
            wr_d    = bus.Wr;
            wdata_d = bus.Data_from_CPU;
            cnt_d   = CNT_LOAD;
        end
        if (state_q == WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (enter_resp) begin
            if (wr_q) begin
                if (hit_mmio) hex_d = wdata_q;
            end else begin
                unique case (1'b1)
                    hit_mmio: dout_d = sw_sync_q;
                    hit_ram:  dout_d = ram_rdata;
                    default:  dout_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        bus.Ready       = (state_q == RESP);
        bus.Data_to_CPU = dout_q;
        Hex_out         = hex_q;
    end

endmodule
